// File: rtl/pwm_ramp_sequencer.sv
// Bus-master sequencer for the 8-channel PWM peripheral: programs periods, duties and
// enables after reset, then slews each channel's duty toward a host-supplied target once per tick.
module pwm_ramp_sequencer #(
   parameter logic [31:0] PERIOD   = 32'd1000000,
   parameter int          TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_ch,
   input  logic [31:0] cmd_target,
   input  logic [31:0] cmd_step,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        w,
   output logic        r,
   output logic [7:0]  settled,
   output logic        busy
);

   typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [31:0] DUTY_BASE = 32'h0000_0024;
   localparam logic [31:0] PER_BASE  = 32'h0000_0004;

   state_t      state_q, state_d;
   logic [4:0]  init_cnt_q, init_cnt_d;
   logic [2:0]  k_q, k_d;
   logic [31:0] tick_q, tick_d;
   logic [31:0] cur_q [8];
   logic [31:0] cur_d [8];
   logic [31:0] tgt_q [8];
   logic [31:0] tgt_d [8];
   logic [31:0] step_q [8];
   logic [31:0] step_d [8];
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        w_q, w_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic [7:0]  settled_q, settled_d;

   logic [31:0] cur_k, tgt_k, step_k, diff_k, nxt_k;
   logic [31:0] init_off, sweep_off;
   logic        tick_wrap;

   // All slewing decisions work on the magnitude of the gap, so cur never passes tgt.
   always_comb begin
      cur_k     = cur_q[k_q];
      tgt_k     = tgt_q[k_q];
      step_k    = step_q[k_q];
      diff_k    = (tgt_k > cur_k) ? (tgt_k - cur_k) : (cur_k - tgt_k);
      if (step_k == 32'd0 || diff_k <= step_k) begin
         nxt_k = tgt_k;
      end else if (tgt_k > cur_k) begin
         nxt_k = cur_k + step_k;
      end else begin
         nxt_k = cur_k - step_k;
      end
      init_off  = {27'd0, init_cnt_q[2:0], 2'b00};
      sweep_off = {27'd0, k_q, 2'b00};
      tick_wrap = (tick_q == TICK_LAST);
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      k_d         = k_q;
      tick_d      = tick_q;
      cur_d       = cur_q;
      tgt_d       = tgt_q;
      step_d      = step_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      w_d         = 1'b0;
      cmd_ready_d = (state_q != INIT);
      busy_d      = (state_q != IDLE);

      // The tick counter runs freely from IDLE entry, including through sweeps.
      if (state_q != INIT) begin
         tick_d = tick_wrap ? 32'd0 : tick_q + 32'd1;
      end

      case (state_q)
         INIT: begin
            w_d        = 1'b1;
            init_cnt_d = init_cnt_q + 5'd1;
            if (init_cnt_q < 5'd8) begin
               addr_d  = PER_BASE + init_off;
               wdata_d = PERIOD;
            end else if (init_cnt_q < 5'd16) begin
               addr_d  = DUTY_BASE + init_off;
               wdata_d = 32'd0;
            end else begin
               addr_d  = 32'd0;
               wdata_d = 32'h0000_00FF;
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (tick_wrap) begin
               state_d = SWEEP;
               k_d     = 3'd0;
            end
         end
         SWEEP: begin
            if (cur_k != tgt_k) begin
               cur_d[k_q] = nxt_k;
               w_d        = 1'b1;
               addr_d     = DUTY_BASE + sweep_off;
               wdata_d    = nxt_k;
            end
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) begin
               state_d = IDLE;
            end
         end
         default: state_d = INIT;
      endcase

      // Commands land after the sweep has read the old target, so they apply next tick.
      if (cmd_valid && cmd_ready_q) begin
         tgt_d[cmd_ch]  = cmd_target;
         step_d[cmd_ch] = cmd_step;
      end

      for (int n = 0; n < 8; n++) begin
         settled_d[n] = (cur_q[n] == tgt_q[n]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         init_cnt_q  <= 5'd0;
         k_q         <= 3'd0;
         tick_q      <= 32'd0;
         for (int n = 0; n < 8; n++) begin
            cur_q[n]  <= 32'd0;
            tgt_q[n]  <= 32'd0;
            step_q[n] <= 32'd0;
         end
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         w_q         <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         settled_q   <= 8'hFF;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         k_q         <= k_d;
         tick_q      <= tick_d;
         for (int n = 0; n < 8; n++) begin
            cur_q[n]  <= cur_d[n];
            tgt_q[n]  <= tgt_d[n];
            step_q[n] <= step_d[n];
         end
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         w_q         <= w_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         settled_q   <= settled_d;
      end
   end

   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign w         = w_q;
   assign r         = 1'b0;
   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign settled   = settled_q;

endmodule
